// File: rtl/coproc_cmd_issuer.sv
// Host-side command issuer for the image coprocessor: latches one command, runs the
// active-low ENABLE strobe, tracks FLAG_DONE busy/complete phases and returns a response.
module coproc_cmd_issuer #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT   = 255,
    parameter int unsigned DONE_TIMEOUT  = 1048575,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_instr,
    input  logic [16:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic [2:0]  INSTRUCTION,
    output logic [16:0] MEM_ADDR,
    output logic [7:0]  DATA_IN,
    output logic        ENABLE,
    input  logic        FLAG_DONE,
    input  logic        FLAG_ERROR,
    input  logic [7:0]  DATA_OUT
);
    localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LIMIT   = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] DONE_LIMIT  = CNT_W'(DONE_TIMEOUT);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_RESET = 3'd7;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_ERR      = 2'b01;
    localparam logic [1:0] ST_ACK_TO   = 2'b10;
    localparam logic [1:0] ST_DONE_TO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_SETTLE,
        S_RESPOND
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_done_sync;
    logic [SYNC_STAGES-1:0] r_err_sync;
    logic                   r_cmd_ready;
    logic                   r_rsp_valid;
    logic [7:0]             r_rsp_data;
    logic [1:0]             r_rsp_status;
    logic                   r_busy;
    logic [2:0]             r_instr;
    logic [16:0]            r_addr;
    logic [7:0]             r_data;
    logic                   r_enable;

    logic                   w_done_s;
    logic                   w_err_s;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_fixed_wait;

    assign w_done_s     = r_done_sync[SYNC_STAGES-1];
    assign w_err_s      = r_err_sync[SYNC_STAGES-1];
    assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_fixed_wait = (r_instr == OP_NOP) || (r_instr == OP_RESET);

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_status  = r_rsp_status;
    assign busy        = r_busy;
    assign INSTRUCTION = r_instr;
    assign MEM_ADDR    = r_addr;
    assign DATA_IN     = r_data;
    assign ENABLE      = r_enable;

    // Coprocessor flags cross into this clock domain through a plain flop chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done_sync <= '0;
            r_err_sync  <= '0;
        end else begin
            r_done_sync <= {r_done_sync[SYNC_STAGES-2:0], FLAG_DONE};
            r_err_sync  <= {r_err_sync[SYNC_STAGES-2:0], FLAG_ERROR};
        end
    end

    // Command sequencer; the shared counter restarts at zero on every state entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= ST_OK;
            r_busy       <= 1'b0;
            r_instr      <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_enable     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_instr     <= cmd_instr;
                        r_addr      <= cmd_addr;
                        r_data      <= cmd_data;
                        r_rsp_data  <= '0;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt    <= '0;
                        r_enable <= 1'b0;
                        r_state  <= S_STROBE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_cnt    <= '0;
                        r_enable <= 1'b1;
                        r_state  <= w_fixed_wait ? S_SETTLE : S_WAIT_ACK;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WAIT_ACK: begin
                    if (!w_done_s) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == ACK_LIMIT) begin
                        r_rsp_status <= ST_ACK_TO;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_done_s) begin
                        r_rsp_status <= w_err_s ? ST_ERR : ST_OK;
                        if (r_instr == OP_LOAD) begin
                            r_rsp_data <= DATA_OUT;
                        end
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESPOND;
                    end else if (r_cnt == DONE_LIMIT) begin
                        r_rsp_status <= ST_DONE_TO;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_rsp_status <= ST_OK;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coproc_cmd_issuer.sv
// Bench for coproc_cmd_issuer: behavioural coprocessor, prediction queue and response monitor.
module tb_coproc_cmd_issuer;
    localparam int unsigned SETUP_CYCLES  = 2;
    localparam int unsigned PULSE_CYCLES  = 4;
    localparam int unsigned SETTLE_CYCLES = 8;
    localparam int unsigned ACK_TIMEOUT   = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_instr = 3'd0;
    logic [16:0] cmd_addr = 17'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [2:0]  INSTRUCTION;
    logic [16:0] MEM_ADDR;
    logic [7:0]  DATA_IN;
    logic        ENABLE;
    logic        FLAG_DONE = 1'b1;
    logic        FLAG_ERROR = 1'b0;
    logic [7:0]  DATA_OUT = 8'd0;

    typedef struct {
        logic [2:0]  instr;
        logic [16:0] addr;
        logic [7:0]  data;
        logic [1:0]  status;
        logic [7:0]  rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   rsp_count = 0;

    bit         cp_never = 1'b0;
    int         cp_ack_dly = 3;
    int         cp_done_len = 9;
    logic       cp_err = 1'b0;
    logic [7:0] cp_dout = 8'h00;

    coproc_cmd_issuer #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .DONE_TIMEOUT (1048575),
        .SYNC_STAGES  (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_instr  (cmd_instr),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .busy       (busy),
        .INSTRUCTION(INSTRUCTION),
        .MEM_ADDR   (MEM_ADDR),
        .DATA_IN    (DATA_IN),
        .ENABLE     (ENABLE),
        .FLAG_DONE  (FLAG_DONE),
        .FLAG_ERROR (FLAG_ERROR),
        .DATA_OUT   (DATA_OUT)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected response derived from the opcode class and what the coprocessor will do.
    function automatic exp_t predict(input logic [2:0] ins, input logic [16:0] a, input logic [7:0] d,
                                     input bit never, input logic err, input logic [7:0] dout);
        exp_t e;
        e.instr  = ins;
        e.addr   = a;
        e.data   = d;
        e.rdata  = 8'h00;
        e.status = 2'b00;
        if (ins != 3'd0 && ins != 3'd7) begin
            if (never) begin
                e.status = 2'b10;
            end else begin
                e.status = err ? 2'b01 : 2'b00;
                if (ins == 3'd1) e.rdata = dout;
            end
        end
        return e;
    endfunction

    // Behavioural coprocessor: reacts to the ENABLE falling edge.
    initial begin
        forever begin
            @(negedge ENABLE);
            if (INSTRUCTION != 3'd0 && INSTRUCTION != 3'd7 && !cp_never) begin
                repeat (cp_ack_dly) @(posedge clock);
                #1;
                FLAG_DONE  = 1'b0;
                FLAG_ERROR = 1'b0;
                repeat (cp_done_len) @(posedge clock);
                #1;
                DATA_OUT   = cp_dout;
                FLAG_ERROR = cp_err;
                @(posedge clock);
                #1;
                FLAG_DONE  = 1'b1;
            end
        end
    end

    // Response monitor and command-pin stability while busy.
    initial begin
        forever begin
            @(negedge clock);
            if (busy === 1'b1)
                check("cmd_pins", 32'({INSTRUCTION, MEM_ADDR, DATA_IN}), 32'({cur.instr, cur.addr, cur.data}));
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                rsp_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=status %0h data %0h required=no response", rsp_status, rsp_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_status", 32'(rsp_status), 32'(mon_e.status));
                    check("rsp_data", 32'(rsp_data), 32'(mon_e.rdata));
                end
            end
        end
    end

    // ENABLE low-pulse width.
    initial begin
        int pw;
        forever begin
            @(negedge ENABLE);
            pw = 0;
            while (ENABLE === 1'b0 && pw < 100) begin
                @(posedge clock);
                #1;
                pw++;
            end
            check("enable_pulse_width", 32'(pw), 32'(PULSE_CYCLES));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input exp_t e, output int lat);
        int n;
        cur = e;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        check("ready_before_cmd", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_instr = e.instr;
        cmd_addr  = e.addr;
        cmd_data  = e.data;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_instr = 3'($urandom);
        cmd_addr  = 17'($urandom);
        cmd_data  = 8'($urandom);
        check("accept_ready_busy", 32'({cmd_ready, busy}), 32'(2'b01));
        n = 0;
        while (ENABLE !== 1'b0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("setup_len", 32'(n), 32'(SETUP_CYCLES));
        n = 0;
        while (ENABLE !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 600) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("rsp_arrives", 32'(rsp_valid), 32'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("return_idle", 32'({busy, cmd_ready, rsp_valid}), 32'(3'b010));
    endtask

    initial begin
        exp_t       e;
        int         lat;
        int         n;
        int         base;
        logic [1:0] s0;
        logic [7:0] d0;
        logic [2:0] ins;

        repeat (3) @(posedge clock);
        #1;
        check("reset_cp_pins", 32'({ENABLE, INSTRUCTION, MEM_ADDR, DATA_IN}), 32'({1'b1, 28'd0}));
        check("reset_host", 32'({cmd_ready, rsp_valid, rsp_data, rsp_status, busy}), 32'({1'b1, 1'b0, 8'd0, 2'd0, 1'b0}));
        reset = 1'b1;
        repeat (4) @(posedge clock);

        // STORE, ordinary completion
        cp_never = 1'b0; cp_ack_dly = 3; cp_done_len = 9; cp_err = 1'b0; cp_dout = 8'h99;
        issue(predict(3'd2, 17'd1234, 8'hA5, cp_never, cp_err, cp_dout), lat);
        wait_idle();

        // LOAD at the last pixel returns DATA_OUT
        cp_dout = 8'h3C;
        issue(predict(3'd1, 17'd76799, 8'h00, cp_never, cp_err, cp_dout), lat);
        wait_idle();

        // ZOOM_IN_VP with no acknowledge: decision on count 255, response one cycle later
        cp_never = 1'b1;
        issue(predict(3'd3, 17'd42, 8'h11, cp_never, cp_err, cp_dout), lat);
        check("ack_timeout_latency", 32'(lat), 32'(ACK_TIMEOUT + 1));
        check("ack_timeout_busy_enable", 32'({busy, ENABLE}), 32'(2'b11));
        wait_idle();
        cp_never = 1'b0;

        // RESET_INST then NOP use the fixed settle wait
        issue(predict(3'd7, 17'd7, 8'h07, cp_never, cp_err, cp_dout), lat);
        check("settle_latency_reset", 32'(lat), 32'(SETTLE_CYCLES));
        wait_idle();
        issue(predict(3'd0, 17'd0, 8'h00, cp_never, cp_err, cp_dout), lat);
        check("settle_latency_nop", 32'(lat), 32'(SETTLE_CYCLES));
        wait_idle();

        // ZOOM_OUT_MP with error, host stalls the response for 5 cycles
        cp_err = 1'b1; rsp_ready = 1'b0;
        issue(predict(3'd5, 17'd2000, 8'h5C, cp_never, cp_err, cp_dout), lat);
        s0 = rsp_status;
        d0 = rsp_data;
        check("stall_status", 32'(s0), 32'(2'b01));
        repeat (5) begin
            @(posedge clock);
            #1;
            check("stall_hold", 32'({rsp_valid, rsp_status, rsp_data, cmd_ready, busy}), 32'({1'b1, s0, d0, 1'b0, 1'b1}));
        end
        rsp_ready = 1'b1;
        wait_idle();
        cp_err = 1'b0;

        // Reset while waiting for completion: no response
        cp_ack_dly = 2; cp_done_len = 40;
        cur = predict(3'd2, 17'd500, 8'h5A, 1'b0, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        cmd_valid = 1'b1; cmd_instr = cur.instr; cmd_addr = cur.addr; cmd_data = cur.data;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (FLAG_DONE !== 1'b0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("model_ack", 32'(FLAG_DONE), 32'(0));
        repeat (6) @(posedge clock);
        #2;
        base = rsp_count;
        reset = 1'b0;
        #1;
        check("reset_midop", 32'({ENABLE, rsp_valid, busy, cmd_ready}), 32'(4'b1001));
        @(posedge clock);
        #1;
        reset = 1'b1;
        n = 0;
        while (FLAG_DONE !== 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        repeat (6) @(posedge clock);
        #1;
        check("no_rsp_after_reset", 32'(rsp_count - base), 32'(0));

        cp_ack_dly = 3; cp_done_len = 9;
        issue(predict(3'd2, 17'd333, 8'h77, cp_never, cp_err, cp_dout), lat);
        wait_idle();

        // Randomized commands and coprocessor behaviour
        for (int i = 0; i < 16; i++) begin
            ins         = 3'($urandom_range(0, 7));
            cp_never    = ($urandom_range(0, 4) == 0);
            cp_ack_dly  = int'($urandom_range(0, 6));
            cp_done_len = int'($urandom_range(8, 20));
            cp_err      = 1'($urandom_range(0, 1));
            cp_dout     = 8'($urandom);
            e = predict(ins, 17'($urandom_range(0, 76799)), 8'($urandom), cp_never, cp_err, cp_dout);
            issue(e, lat);
            if (ins == 3'd0 || ins == 3'd7)
                check("rand_settle_latency", 32'(lat), 32'(SETTLE_CYCLES));
            else if (cp_never)
                check("rand_ack_timeout_latency", 32'(lat), 32'(ACK_TIMEOUT + 1));
            wait_idle();
        end

        repeat (4) @(posedge clock);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
